keystate_pipe: RTL
==================

// Module: keystate_pipe
// PURPOSE
//  Parametrised, flow-controlled key-state generator. The input state is split into LANES lanes
//  of LANE_W bits, lane 0 at the MSB end. The lanes are XOR-folded one lane per pipeline stage,
//  optionally starting from a chaining seed instead of zero, and the folded value is XORed with
//  XOR_CONST. The output is {delayed state, folded value}, used as the sponge key for the next hash round.
//  Unlike the fixed 16x64 free-running version, this block adds valid/ready flow control with
//  stall, a seed-chaining mode, an optional output register, and an occupancy count.
// PARAMETERS
//  LANE_W     64                   lane width in bits (>=1)
//  LANES      16                   number of lanes; also number of fold steps (>=2)
//  XOR_CONST  {LANE_W/2{2'b01}}    constant XORed into the folded lane (default 0x5555...)
//  OUT_REG    0                    1 = registered output stage; adds 1 cycle of latency
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  asynchronous reset, active-high
//  in_valid   in   1                  input state/seed valid
//  in_ready   out  1                  block accepts input this cycle
//  in_state   in   LANES*LANE_W       state; lane j = in_state[(LANES-j)*LANE_W-1 -: LANE_W]
//  in_seed    in   LANE_W             chaining seed
//  in_chain   in   1                  1 = fold starts from in_seed, 0 = fold starts from 0
//  out_valid  out  1                  out_key valid
//  out_ready  in   1                  downstream accepts out_key
//  out_key    out  (LANES+1)*LANE_W   {state, seed ^ lane0 ^ ... ^ lane(LANES-1) ^ XOR_CONST}
//  occupancy  out  $clog2(LANES+OUT_REG+1)  number of valid items in flight
// BEHAVIOUR
//  - Depth D = LANES-1+OUT_REG stages. Stage 1 captures {state, (in_chain ? in_seed : 0) ^ lane0}.
//    Stage k (2..LANES-1) captures {state_k-1, acc_k-1 ^ lane(k-1) of state_k-1}.
//  - Final fold (acc_LANES-1 ^ lane LANES-1 ^ XOR_CONST) is combinational from the last fold stage
//    when OUT_REG=0. When OUT_REG=1 it is registered in stage LANES.
//  - Latency from accept (in_valid & in_ready) to out_valid: D cycles, with no stall.
//  - Flow control uses a single global enable: adv = ~out_valid | out_ready; in_ready = adv.
//    When adv=1, every stage shifts by one, including valid bits.
//    When adv=0, every stage holds, and out_key/out_valid stay stable.
//  - Bubbles are not collapsed. A cycle with in_valid=0 and adv=1 inserts an invalid stage.
//  - Throughput: 1 item per cycle while out_ready=1. Output order equals input order.
//  - in_seed and in_chain are sampled only on accept.
//  - occupancy counts valid stage bits:
//    +1 on accept only, -1 on output fire (out_valid & out_ready) only,
//    unchanged when both or neither occur. Never exceeds D.
//  - Pipeline full (occupancy=D), out_ready=0: in_ready=0; any offered input is not accepted.
//  - Pipeline full, out_ready=1: output fire and accept occur in the same cycle; occupancy stays D.
//  - Reset (async assert, sampled release): all valid bits, acc and state registers go to 0.
//    out_valid=0 and occupancy=0.
//    out_key=0 when OUT_REG=1; out_key={0, 0^XOR_CONST} when OUT_REG=0.
//    Reset mid-operation discards all in-flight items; no stale item emerges after release.
//  - Arithmetic is pure bitwise XOR; no carries; all widths exact.
// TESTING  (LANES=16, LANE_W=64, XOR_CONST=0x5555555555555555)
//  1. OUT_REG=0, in_state=0, in_chain=0, out_ready=1, one accept
//     -> out_valid exactly 15 cycles later; out_key[63:0]=0x5555555555555555; upper 1024 bits = 0.
//  2. lane0=0xFFFFFFFFFFFFFFFF, other lanes 0 -> low word 0xAAAAAAAAAAAAAAAA, upper bits = in_state.
//     lane j=j (j=0..15) -> low word 0x5555555555555555.
//  3. in_state=0, in_chain=1, in_seed=0x1 -> low word 0x5555555555555554.
//     Next item with in_chain=0 and the same seed -> low word 0x5555555555555555.
//  4. 20 back-to-back accepts, out_ready=1 -> 20 consecutive out_valid cycles, starting 15 cycles
//     after the first accept, in order, each matching a reference model.
//  5. Fill pipeline, then hold out_ready=0 for 5 cycles -> in_ready=0, occupancy=15, out_key stable.
//     Release -> one output per cycle. Repeat with OUT_REG=1: occupancy=16, latency 16.
//  6. Assert rst asynchronously after 8 accepts -> out_valid=0 and occupancy=0 before the next
//     clock edge; no output for 15 cycles after release without new input.

Source files
------------

// File: rtl/keystate_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : keystate_pipe_if
// Brief  : valid/ready bus carrying state/seed in and folded key out
// Rev    : 1.0
// ============================================================================
interface keystate_pipe_if #(
  parameter int LANE_W = 64,
  parameter int LANES  = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*LANE_W-1:0]     in_state;
  logic [LANE_W-1:0]           in_seed;
  logic                        in_chain;
  logic                        out_valid;
  logic                        out_ready;
  logic [(LANES+1)*LANE_W-1:0] out_key;

  modport master (
    output in_valid, in_state, in_seed, in_chain, out_ready,
    input  in_ready, out_valid, out_key
  );

  modport slave (
    input  in_valid, in_state, in_seed, in_chain, out_ready,
    output in_ready, out_valid, out_key
  );
endinterface
`default_nettype wire

// File: rtl/keystate_pipe.sv
`default_nettype none
// ============================================================================
// Module : keystate_pipe
// Brief  : lane-by-lane XOR fold of a state word into a sponge key, stallable
// Rev    : 1.0
// ============================================================================
module keystate_pipe #(
  parameter int                LANE_W    = 64,
  parameter int                LANES     = 16,
  parameter logic [LANE_W-1:0] XOR_CONST = {LANE_W/2{2'b01}},
  parameter int                OUT_REG   = 0
) (
  input  wire logic                                clk,
  input  wire logic                                rst,
  keystate_pipe_if.slave                           bus,
  output logic [$clog2(LANES+OUT_REG+1)-1:0]       occupancy
);
  localparam int SW    = LANES * LANE_W;
  localparam int KW    = SW + LANE_W;
  localparam int NF    = LANES - 1;
  localparam int OCC_W = $clog2(LANES + OUT_REG + 1);
  localparam logic [OCC_W-1:0] c_one = OCC_W'(1);

  logic              w_adv;
  logic              w_accept;
  logic              w_fire;
  logic [LANE_W-1:0] w_seed;
  logic [LANE_W-1:0] w_fold;
  logic [OCC_W-1:0]  r_occ;

  logic              r_vld   [1:NF];
  logic [SW-1:0]     r_state [1:NF];
  logic [LANE_W-1:0] r_acc   [1:NF];

  // One global enable: the whole pipe, bubbles included, moves or holds together
  assign w_adv        = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = w_adv;
  assign w_accept     = bus.in_valid & w_adv;
  assign w_fire       = bus.out_valid & bus.out_ready;
  assign w_seed       = bus.in_chain ? bus.in_seed : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= NF; k++) begin
        r_vld[k]   <= 1'b0;
        r_state[k] <= '0;
        r_acc[k]   <= '0;
      end
    end else if (w_adv) begin
      r_vld[1]   <= bus.in_valid;
      r_state[1] <= bus.in_state;
      r_acc[1]   <= w_seed ^ bus.in_state[SW-1 -: LANE_W];
      // Stage k folds in lane k-1, which sits (LANES-k+1) lanes up from the LSB
      for (int k = 2; k <= NF; k++) begin
        r_vld[k]   <= r_vld[k-1];
        r_state[k] <= r_state[k-1];
        r_acc[k]   <= r_acc[k-1] ^ r_state[k-1][(LANES-k+1)*LANE_W-1 -: LANE_W];
      end
    end
  end

  assign w_fold = r_acc[NF] ^ r_state[NF][LANE_W-1:0] ^ XOR_CONST;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          r_out_vld;
      logic [KW-1:0] r_out_key;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out_vld <= 1'b0;
          r_out_key <= '0;
        end else if (w_adv) begin
          r_out_vld <= r_vld[NF];
          r_out_key <= {r_state[NF], w_fold};
        end
      end

      assign bus.out_valid = r_out_vld;
      assign bus.out_key   = r_out_key;
    end else begin : g_out_comb
      assign bus.out_valid = r_vld[NF];
      assign bus.out_key   = {r_state[NF], w_fold};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (w_accept && !w_fire) begin
      r_occ <= r_occ + c_one;
    end else if (w_fire && !w_accept) begin
      r_occ <= r_occ - c_one;
    end
  end

  assign occupancy = r_occ;
endmodule
`default_nettype wire
